// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared state encoding and sizing helper for period_chain
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } pc_state_t;

  // Fill counter must hold STAGES-1; the extra bit keeps STAGES=1 legal.
  function automatic int fill_width(input int stages);
    return $clog2(stages) + 1;
  endfunction

endpackage

// File: rtl/period_divider.sv
// rtl/period_divider.sv - programmable cycle divider with combinational fire
module period_divider #(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic [PERIOD_W-1:0] cnt,
  output logic                fire
);

  logic [PERIOD_W-1:0] r_cnt;
  logic                w_active;

  assign w_active = enable && (period != '0);
  // >= rather than == so a period lowered below the running count fires at once
  assign fire     = w_active && (r_cnt >= (period - PERIOD_W'(1)));
  assign cnt      = r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (w_active) begin
      r_cnt <= fire ? '0 : r_cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/period_chain.sv
// rtl/period_chain.sv - loadable periodic counter feeding an increment chain
module period_chain
  import pc_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int STAGES   = 3,
  parameter int PERIOD_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [WIDTH-1:0]        load_val,
  input  logic                    run,
  input  logic [PERIOD_W-1:0]     period,
  output logic [STAGES*WIDTH-1:0] stage_out,
  output logic                    tick,
  output logic                    valid
);

  localparam int FILL_W = fill_width(STAGES);

  pc_state_t           r_state;
  pc_state_t           w_state_nxt;
  logic [FILL_W-1:0]   r_fill;
  logic [FILL_W-1:0]   w_fill_nxt;
  logic                r_valid;
  logic                w_valid_nxt;
  logic                r_tick;
  logic                w_fire;
  logic                w_div_en;
  logic [PERIOD_W-1:0] w_cnt;
  logic [WIDTH-1:0]    r_stage [STAGES];

  assign w_div_en = (r_state == RUN) && run;

  period_divider #(
    .PERIOD_W (PERIOD_W)
  ) u_div (
    .clk    (clk),
    .reset  (reset),
    .clear  (load),
    .enable (w_div_en),
    .period (period),
    .cnt    (w_cnt),
    .fire   (w_fire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    w_valid_nxt = r_valid;
    if (load) begin
      if (STAGES > 1) begin
        w_state_nxt = FILL;
        w_fill_nxt  = FILL_W'(STAGES - 1);
        w_valid_nxt = 1'b0;
      end else begin
        w_state_nxt = RUN;
        w_fill_nxt  = '0;
        w_valid_nxt = 1'b1;
      end
    end else if (r_state == FILL) begin
      w_fill_nxt = r_fill - FILL_W'(1);
      if (r_fill <= FILL_W'(1)) begin
        w_fill_nxt  = '0;
        w_state_nxt = RUN;
        w_valid_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_fill     <= '0;
      r_valid    <= 1'b0;
      r_tick     <= 1'b0;
      r_stage[0] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fill  <= w_fill_nxt;
      r_valid <= w_valid_nxt;
      // load wins over a tick falling due in the same cycle
      r_tick  <= w_fire && !load;
      if (load) begin
        r_stage[0] <= load_val;
      end else if (w_fire) begin
        r_stage[0] <= r_stage[0] + WIDTH'(1);
      end
    end
  end

  genvar k;
  generate
    for (k = 1; k < STAGES; k++) begin : g_chain
      always_ff @(posedge clk) begin
        if (reset) begin
          r_stage[k] <= '0;
        end else begin
          r_stage[k] <= r_stage[k-1] + WIDTH'(1);
        end
      end
    end
    for (k = 0; k < STAGES; k++) begin : g_out
      assign stage_out[k*WIDTH +: WIDTH] = r_stage[k];
    end
  endgenerate

  assign tick  = r_tick;
  assign valid = r_valid;

endmodule

// File: doc/period_chain.md
# period_chain

Parametrised periodic counter with a dependent increment chain, for stimulus generation and self-checking in the CPU simulation benches. Stage 0 is a loadable WIDTH-bit counter that advances by one every PERIOD clock cycles. Each later stage registers its predecessor plus one, giving values x, x+1, x+2, … with a known per-stage lag. The block is synthesizable and clocked: the counter steps on a programmable cycle divider, and a fill phase after each load qualifies the chain outputs.

## Interface
- WIDTH, 32: data width of every stage.
- STAGES, 3: number of chain stages, STAGES ≥ 1.
- PERIOD_W, 8: width of the period input and divider counter.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; dominates every other input.
- load  in  1  when high, stage 0 takes load_val and a fill phase starts.
- load_val  in  WIDTH  value loaded into stage 0.
- run  in  1  enables the divider in RUN; when low, the divider holds.
- period  in  PERIOD_W  cycles per stage-0 increment; 0 means hold.
- stage_out  out  STAGES*WIDTH  stage k occupies bits [k*WIDTH +: WIDTH].
- tick  out  1  one-cycle pulse coincident with a new stage-0 value.
- valid  out  1  chain is consistent: stage k = stage 0 + k, modulo the settling lag after a tick.

## Operation
- **States:** IDLE, FILL, RUN.
- **Reset:** every stage = 0, divider cnt = 0, fill counter = 0, tick = 0, valid = 0, state = IDLE.
- **IDLE:**
  - Stage 0 and the divider hold.
  - Stages ≥ 1 propagate: stage k ← stage k-1 + 1, every cycle, in every state.
- **load (any state):**
  - stage 0 ← load_val; cnt ← 0; tick ← 0; valid ← 0.
  - With STAGES > 1: fill counter ← STAGES-1, state ← FILL.
  - With STAGES = 1: state ← RUN and valid ← 1 at the same edge.
  - load beats any tick that is due in the same cycle.
- **FILL:**
  - Stage 0 and the divider hold.
  - The fill counter decrements each edge.
  - At the edge where it reaches 0: state ← RUN, valid ← 1.
- **RUN, run=1, period≠0:**
  - If cnt ≥ period-1: stage 0 ← stage 0 + 1, cnt ← 0, tick ← 1.
  - Otherwise cnt ← cnt + 1, tick ← 0.
  - Because the compare is ≥, lowering period mid-count below cnt+1 fires on the next edge.
- **RUN, run=0 or period=0:** cnt and stage 0 hold; tick ← 0.
- **Arithmetic:**
  - All adds are WIDTH bits and wrap modulo 2^WIDTH (0xFFFFFFFF + 1 = 0).
  - cnt is PERIOD_W bits; period-1 is computed only when period ≠ 0.
- valid stays 1 in RUN; it drops only on load or reset.

## Timing
- Load sampled at edge E0: stage 0 = load_val after E0; stage k = load_val + k after E0+k.
- valid rises after edge E0+STAGES-1.
- First increment lands at edge E0+STAGES-1+period, with run held high.
- Increments are then spaced exactly period edges apart.
- tick is registered: high for the one cycle after the edge that updated stage 0.
- A stage-0 change reaches stage k k edges later; valid does not mask this lag.
- Reset asserted mid-FILL or mid-RUN: all outputs return to their reset values at that edge; load in the same cycle is ignored.

## Structure
- Shared package pc_pkg:
  - state enum {IDLE, FILL, RUN}.
  - Localparam for the fill counter width, $clog2(STAGES)+1.
- Sub-module period_divider:
  - Inputs: clk, reset, clear, enable, period.
  - Outputs: the cnt register and a combinational fire.
  - The top level gates it with state and load.
- The chain is a generate loop of WIDTH-bit registers.

## Test plan
- **Load and count** (STAGES=3, load_val=5, period=7, run=1):
  - stage_out = {7,6,5} and valid=1 after E2.
  - Stage 0 = 6 and tick=1 after E9; stage 2 = 8 after E11.
- **Wrap:** load_val=0xFFFFFFFF, period=1 → stage 0 = 0 at the first tick; stage 1 = 1 one edge later.
- **Hold:**
  - period=0 in RUN → no tick for 50 cycles, stage 0 constant.
  - run low with cnt=3 holds cnt; raising run resumes the count from 3.
- **Period change:** cnt=5, period lowered from 7 to 3 → tick on the next edge.
- **Load collision:** load asserted in the cycle a tick is due → stage 0 = load_val, no tick, valid=0, state FILL.
- **Reset mid-FILL** with load also high → all stages 0, valid=0, tick=0, state IDLE; STAGES=1 variant reaches valid=1 at the load edge.
